// File: rtl/single_macc_interpolator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : single_macc_interpolator_pkg
// Purpose  : shared widths, sequencer states and output saturation
// Revision : 1.0
// ============================================================================
package single_macc_interpolator_pkg;

   localparam int DataW      = 18;
   localparam int CoeffW     = 18;
   localparam int ProdW      = 36;
   localparam int AccW       = 40;
   localparam int CoeffAddrW = 4;
   localparam int NumCoeffs  = 16;
   localparam int FracW      = 17;

   localparam logic signed [AccW-1:0] c_SatMax = AccW'((2 ** (DataW - 1)) - 1);
   localparam logic signed [AccW-1:0] c_SatMin = AccW'(-(2 ** (DataW - 1)));

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seqState_e;

   // Q.34 accumulator back to Q1.17: arithmetic shift, then clamp.
   function automatic logic signed [DataW-1:0] saturate(input logic signed [AccW-1:0] acc);
      logic signed [AccW-1:0] scaled;
      scaled = acc >>> FracW;
      if (scaled > c_SatMax) begin
         return c_SatMax[DataW-1:0];
      end else if (scaled < c_SatMin) begin
         return c_SatMin[DataW-1:0];
      end else begin
         return scaled[DataW-1:0];
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/smi_coeff_ram.sv
`default_nettype none
// ============================================================================
// Module   : smi_coeff_ram
// Purpose  : 16x18 simple dual-port coefficient RAM, registered read
// Revision : 1.0
// ============================================================================
module smi_coeff_ram
   import single_macc_interpolator_pkg::*;
(
   input  logic                  Clk_i,
   input  logic                  WrEn_i,
   input  logic [CoeffAddrW-1:0] WrAddr_i,
   input  logic [CoeffW-1:0]     WrData_i,
   input  logic [CoeffAddrW-1:0] RdAddr_i,
   output logic [CoeffW-1:0]     RdData_o
);

   logic [CoeffW-1:0] r_mem [NumCoeffs];

   // Read-before-write: a same-address collision returns the old word.
   always_ff @(posedge Clk_i) begin
      if (WrEn_i) begin
         r_mem[WrAddr_i] <= WrData_i;
      end
      RdData_o <= r_mem[RdAddr_i];
   end

endmodule
`default_nettype wire

// File: rtl/single_macc_interpolator.sv
`default_nettype none
// ============================================================================
// Module   : single_macc_interpolator
// Purpose  : polyphase FIR interpolator sharing one signed MAC over 16 cycles
// Revision : 1.0
// ============================================================================
module single_macc_interpolator
   import single_macc_interpolator_pkg::*;
#(
   parameter int InterpolationK = 2
)(
   input  logic                  Clk_i,
   input  logic                  Rst_i,
   input  logic [CoeffAddrW-1:0] CoeffAddr_i,
   input  logic [CoeffW-1:0]     CoeffData_i,
   input  logic                  CoeffWr_i,
   input  logic [DataW-1:0]      Data_i,
   input  logic                  DataNd_i,
   output logic [DataW-1:0]      Data_o,
   output logic                  DataValid_o
);

   localparam int TapsPerPhase = NumCoeffs / InterpolationK;
   localparam int TapShift     = $clog2(TapsPerPhase);
   localparam int TapW         = (TapsPerPhase > 1) ? TapShift : 1;
   localparam logic [TapW-1:0]       c_TapMask   = TapW'(TapsPerPhase - 1);
   localparam logic [CoeffAddrW-1:0] c_LastCycle = CoeffAddrW'(NumCoeffs - 1);

   seqState_e             r_state, w_nextState;
   logic [CoeffAddrW-1:0] r_cycle, w_nextCycle;
   logic                  w_accept;

   logic [DataW-1:0]      r_delay [TapsPerPhase];
   logic [TapW-1:0]       r_newest;
   logic [TapW-1:0]       w_tap, w_wrIdx, w_rdIdx;
   logic [CoeffAddrW-1:0] w_phase, w_rdAddr;

   logic                  r_s1Valid, r_s1First, r_s1Last;
   logic [DataW-1:0]      r_s1Sample;
   logic [CoeffW-1:0]     r_s1Coeff;
   logic                  r_s2Valid, r_s2First, r_s2Last;
   logic signed [ProdW-1:0] r_prod, w_mulA, w_mulB;
   logic signed [AccW-1:0]  r_acc, w_prodExt;
   logic                  r_s3Valid, r_s3Last;

   always_comb begin
      w_nextState = r_state;
      w_nextCycle = r_cycle;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (DataNd_i) begin
               w_accept    = 1'b1;
               w_nextState = RUN;
               w_nextCycle = '0;
            end
         end
         RUN: begin
            w_nextCycle = r_cycle + CoeffAddrW'(1);
            // The final RUN cycle doubles as an IDLE slot for the next sample.
            if (r_cycle == c_LastCycle) begin
               w_nextState = IDLE;
               w_nextCycle = '0;
               if (DataNd_i) begin
                  w_accept    = 1'b1;
                  w_nextState = RUN;
               end
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   assign w_tap    = TapW'(r_cycle) & c_TapMask;
   assign w_phase  = r_cycle >> TapShift;
   assign w_rdAddr = CoeffAddrW'(int'(w_tap) * InterpolationK + int'(w_phase));
   assign w_wrIdx  = (r_newest + TapW'(1)) & c_TapMask;
   assign w_rdIdx  = (r_newest - w_tap) & c_TapMask;

   always_ff @(posedge Clk_i or negedge Rst_i) begin
      if (!Rst_i) begin
         r_state  <= IDLE;
         r_cycle  <= '0;
         r_newest <= '0;
         for (int i = 0; i < TapsPerPhase; i++) begin
            r_delay[i] <= '0;
         end
      end else begin
         r_state <= w_nextState;
         r_cycle <= w_nextCycle;
         if (w_accept) begin
            r_delay[w_wrIdx] <= Data_i;
            r_newest         <= w_wrIdx;
         end
      end
   end

   smi_coeff_ram u_coeffRam (
      .Clk_i    (Clk_i),
      .WrEn_i   (CoeffWr_i),
      .WrAddr_i (CoeffAddr_i),
      .WrData_i (CoeffData_i),
      .RdAddr_i (w_rdAddr),
      .RdData_o (r_s1Coeff)
   );

   assign w_mulA    = ProdW'($signed(r_s1Sample));
   assign w_mulB    = ProdW'($signed(r_s1Coeff));
   assign w_prodExt = {{(AccW - ProdW){r_prod[ProdW-1]}}, r_prod};

   always_ff @(posedge Clk_i or negedge Rst_i) begin
      if (!Rst_i) begin
         r_s1Valid   <= 1'b0;
         r_s1First   <= 1'b0;
         r_s1Last    <= 1'b0;
         r_s1Sample  <= '0;
         r_s2Valid   <= 1'b0;
         r_s2First   <= 1'b0;
         r_s2Last    <= 1'b0;
         r_prod      <= '0;
         r_s3Valid   <= 1'b0;
         r_s3Last    <= 1'b0;
         r_acc       <= '0;
         Data_o      <= '0;
         DataValid_o <= 1'b0;
      end else begin
         r_s1Valid  <= (r_state == RUN);
         r_s1First  <= (w_tap == '0);
         r_s1Last   <= (w_tap == c_TapMask);
         r_s1Sample <= r_delay[w_rdIdx];

         r_s2Valid <= r_s1Valid;
         r_s2First <= r_s1First;
         r_s2Last  <= r_s1Last;
         r_prod    <= w_mulA * w_mulB;

         r_s3Valid <= r_s2Valid;
         r_s3Last  <= r_s2Last;
         if (r_s2Valid) begin
            r_acc <= r_s2First ? w_prodExt : r_acc + w_prodExt;
         end

         DataValid_o <= r_s3Valid && r_s3Last;
         if (r_s3Valid && r_s3Last) begin
            Data_o <= saturate(r_acc);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_single_macc_interpolator.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for single_macc_interpolator: random samples checked against a direct
// polyphase convolution model through an expected-output queue.
module tb_single_macc_interpolator;

   localparam int K = 2;
   localparam int T = 16 / K;

   logic        Clk       = 1'b0;
   logic        Rst       = 1'b1;
   logic [3:0]  CoeffAddr = '0;
   logic [17:0] CoeffData = '0;
   logic        CoeffWr   = 1'b0;
   logic [17:0] DataIn    = '0;
   logic        DataNd    = 1'b0;
   logic [17:0] DataOut;
   logic        DataValid;

   typedef struct {
      int     value;
      longint cycle;
   } expect_t;

   expect_t expQ [$];
   int      h [16];
   int      hist [$];
   longint  cyc        = 0;
   longint  busyUntil  = 0;
   int      compared   = 0;
   int      mismatched = 0;

   single_macc_interpolator #(.InterpolationK(K)) dut (
      .Clk_i       (Clk),
      .Rst_i       (Rst),
      .CoeffAddr_i (CoeffAddr),
      .CoeffData_i (CoeffData),
      .CoeffWr_i   (CoeffWr),
      .Data_i      (DataIn),
      .DataNd_i    (DataNd),
      .Data_o      (DataOut),
      .DataValid_o (DataValid)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   function automatic int rnd18();
      logic signed [17:0] v;
      v = 18'($urandom);
      return int'(v);
   endfunction

   // y_p = sum_m x[n-m] * h[m*K + p], rescaled to Q1.17 and clamped.
   function automatic int refPhase(int p);
      longint acc = 0;
      for (int m = 0; m < T; m++) begin
         acc += longint'(hist[m]) * longint'(h[m * K + p]);
      end
      acc = acc >>> 17;
      if (acc > 131071) acc = 131071;
      else if (acc < -131072) acc = -131072;
      return int'(acc);
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clearHistory();
      hist.delete();
      for (int i = 0; i < T; i++) hist.push_back(0);
   endtask

   task automatic checkVal(input string name, input int got, input int want);
      compared++;
      if (got != want) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic driveSample(input int value);
      longint t0;
      t0     = cyc + 1;
      DataIn = 18'(value);
      DataNd = 1'b1;
      if (t0 >= busyUntil) begin
         hist.push_front(value);
         void'(hist.pop_back());
         for (int p = 0; p < K; p++) begin
            expQ.push_back('{value: refPhase(p), cycle: t0 + longint'((p + 1) * T + 3)});
         end
         busyUntil = t0 + 16;
      end
      step();
      DataNd = 1'b0;
   endtask

   // extra=1 raises a stray strobe at t0+5, which must be ignored.
   task automatic sendSample(input int value, input int gap, input bit extra);
      driveSample(value);
      for (int i = 1; i < gap; i++) begin
         DataNd = extra && (i == 5);
         if (DataNd) DataIn = 18'(rnd18());
         step();
      end
      DataNd = 1'b0;
   endtask

   task automatic writeCoeff(input int addr, input int value);
      while (cyc + 1 <= busyUntil) step();
      CoeffAddr = 4'(addr);
      CoeffData = 18'(value);
      CoeffWr   = 1'b1;
      h[addr]   = value;
      step();
      CoeffWr   = 1'b0;
   endtask

   task automatic impulseSweep();
      repeat (T) sendSample(0, 16, 1'b0);
      sendSample(65536, 16, 1'b0);
      repeat (T) sendSample(0, 16, 1'b0);
   endtask

   initial begin
      expect_t e;
      int      got;
      forever begin
         @(negedge Clk);
         got = int'($signed(DataOut));
         if (DataValid) begin
            compared++;
            if (expQ.size() == 0) begin
               mismatched++;
               $display("FAIL unexpectedPulse: got Data_o=%0d at cycle %0d, required no pulse", got, cyc);
            end else begin
               e = expQ.pop_front();
               if (got != e.value || cyc != e.cycle) begin
                  mismatched++;
                  $display("FAIL output: got %0d at cycle %0d, required %0d at cycle %0d",
                           got, cyc, e.value, e.cycle);
               end
            end
         end else if (expQ.size() > 0 && expQ[0].cycle <= cyc) begin
            compared++;
            mismatched++;
            e = expQ.pop_front();
            $display("FAIL missingPulse: got no pulse at cycle %0d, required Data_o=%0d", e.cycle, e.value);
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got no completion by %0t, required self-termination", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      clearHistory();
      for (int i = 0; i < 16; i++) h[i] = 0;
      #2 Rst = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      checkVal("resetDataO", int'(DataOut), 0);
      checkVal("resetValid", int'(DataValid), 0);
      Rst = 1'b1;
      step();

      // Zero data: pulse timing only.
      repeat (3) sendSample(0, 16, 1'b0);

      // Single half-scale tap.
      for (int i = 0; i < 16; i++) writeCoeff(i, (i == 0) ? 65536 : 0);
      sendSample(131071, 16, 1'b0);
      repeat (T) sendSample(0, 16, 1'b0);

      // Full-scale saturation both ways, back-to-back samples.
      for (int i = 0; i < 16; i++) writeCoeff(i, 131071);
      repeat (9) sendSample(131071, 16, 1'b0);
      repeat (9) sendSample(-131072, 16, 1'b0);

      // Impulse response exposes phase/tap indexing.
      for (int i = 0; i < 16; i++) writeCoeff(i, rnd18());
      impulseSweep();

      // Stray strobes during RUN.
      repeat (4) sendSample(rnd18(), 16, 1'b1);

      // Reset just before t0+9 of a running sample.
      sendSample(131071, 16, 1'b0);
      driveSample(rnd18());
      repeat (8) step();
      #1;
      Rst = 1'b0;
      expQ.delete();
      busyUntil = 0;
      clearHistory();
      #1;
      checkVal("midResetDataO", int'(DataOut), 0);
      checkVal("midResetValid", int'(DataValid), 0);
      step();
      repeat (3) step();
      Rst = 1'b1;
      repeat (30) step();

      // Coefficients must survive the reset.
      impulseSweep();

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) writeCoeff(int'($urandom_range(0, 15)), rnd18());
         sendSample(rnd18(), int'($urandom_range(16, 22)), 1'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 100 && expQ.size() > 0; i++) step();
      while (expQ.size() > 0) begin
         expect_t e;
         e = expQ.pop_front();
         compared++;
         mismatched++;
         $display("FAIL drain: got no pulse, required Data_o=%0d at cycle %0d", e.value, e.cycle);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/single_macc_interpolator.md
Name: single_macc_interpolator

Overview:
Polyphase FIR interpolator by InterpolationK built around one time-shared signed multiply-accumulate unit.
- Each accepted input sample produces InterpolationK output samples.
- Coefficients come from a 16-entry RAM that the host writes at run time.
- It sits between a low-rate sample source and a higher-rate datapath, all on one clock.

Parameters:
InterpolationK, 2, interpolation factor; legal values 1, 2, 4, 8, 16 (must divide 16).
Derived localparam NumCoeffs = 16 (fixed, matches 4-bit coefficient address).
Derived localparam TapsPerPhase T = 16 / InterpolationK.

Ports:
Clk_i  in  1  sole clock; all logic on rising edge, including coefficient writes.
Rst_i  in  1  asynchronous active-low reset.
CoeffAddr_i  in  4  coefficient RAM write address.
CoeffData_i  in  18  coefficient, signed Q1.17.
CoeffWr_i  in  1  write strobe; writes CoeffData_i to CoeffAddr_i at the clock edge.
Data_i  in  18  input sample, signed Q1.17.
DataNd_i  in  1  new-data strobe, one cycle per sample.
Data_o  out  18  output sample, signed Q1.17.
DataValid_o  out  1  one-cycle pulse per output sample.

Behaviour:
Reset (Rst_i=0, asynchronous) clears:
- sequencer to IDLE
- delay line (T x 18 bits) to zero
- pipeline registers and accumulator
- Data_o to 0 and DataValid_o to 0

Coefficient RAM:
- Not reset; contents are retained across reset.
- Power-up contents are all zero.

Input acceptance:
- DataNd_i high in IDLE at edge t0 → Data_i is written into the circular delay line as x[n], and the sequencer enters RUN.
- RUN lasts exactly 16 cycles (t0+1 .. t0+16), then returns to IDLE.
- DataNd_i high at t0+16 is accepted, so the minimum input spacing is 16 cycles.
- DataNd_i while in RUN (before t0+16) is ignored.

MAC schedule:
- Cycle index c = 0..15 within RUN; phase p = c / T, tap m = c mod T.
- Operand pair is x[n-m] and h[m*InterpolationK + p].

Pipeline (3 stages):
- Stage 1: register the synchronous coefficient RAM read and the delay-line read.
- Stage 2: register the 36-bit signed product.
- Stage 3: accumulate into a 40-bit signed accumulator; the accumulator loads the product (does not add) when m = 0.

Output:
- Data_o is acc >>> 17 (arithmetic shift, truncation), saturated to the range [-131072, 131071].
- Data_o is registered and holds its value between pulses.
- Phase p output: DataValid_o pulses at t0 + (p+1)*T + 3.
- For K=2 (T=8): pulses at t0+11 and t0+19.
- The last pulse may overlap the next sample's RUN; the pipeline is fully overlapped.

Coefficient write during RUN:
- Permitted.
- A read and write of the same address in the same cycle returns the old value.

Reset mid-RUN: outputs drop immediately, no pending pulse is emitted, and the delay history is lost.

Decomposition:
Package single_macc_interpolator_pkg holds:
- widths: DataW=18, CoeffW=18, ProdW=36, AccW=40, CoeffAddrW=4, NumCoeffs=16
- the IDLE/RUN state enum
- the saturate function

Natural sub-module: smi_coeff_ram, a 16x18 simple dual-port RAM (write port and synchronous read port, both on Clk_i).
Sequencer, delay line and MAC pipeline stay in the top level.

Test Plan:
1. Reset, all coefficients zero, DataNd_i every 16 cycles with Data_i=0 → DataValid_o pulses at t0+11 and t0+19; Data_o=0.
2. h[0]=0x10000 (0.5), all other coefficients 0, K=2, single sample 0x1FFFF → first pulse Data_o=0x0FFFF; second pulse 0.
3. h[0..15]=0x1FFFF, Data_i=0x1FFFF held for 8+ samples → Data_o saturates to 0x1FFFF; with Data_i=0x20000 it saturates to 0x20000.
4. Impulse response: one sample 0x10000 then zeros, distinct h[k] → output sequence over successive pulses equals h[0], h[1], ..., h[15] each scaled by 0.5 (with truncation), which confirms the phase/tap indexing.
5. DataNd_i asserted at t0+5 during RUN → ignored; the pulse count stays at exactly 2 per accepted sample.
6. Rst_i pulled low at t0+9 → Data_o=0 and DataValid_o=0 immediately; no pulses until the next accepted sample; coefficients are preserved.
